// File: rtl/mbist_mem_scheduler_pkg.sv
// Shared types and default constants for the MBIST memory scheduler.
package mbist_mem_scheduler_pkg;

  localparam int SETTLE_CYC_DEF  = 2;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE_S,
    SETTLE_S,
    START_S,
    RUN_S,
    DONE_S
  } t_sched_state;

endpackage

// File: rtl/mbist_next_mem_pe.sv
// Combinational priority encoder: lowest enabled index above (or at, when incl) start_idx.
module mbist_next_mem_pe #(
  parameter int MEM_NUM   = 4,
  parameter int MEM_IDX_W = 2
) (
  input  logic [MEM_NUM-1:0]   en,
  input  logic [MEM_IDX_W-1:0] start_idx,
  input  logic                 incl,
  output logic                 found,
  output logic [MEM_IDX_W-1:0] idx
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = MEM_NUM - 1; i >= 0; i--) begin
      if (en[i] && ((i > int'(start_idx)) || (incl && (i == int'(start_idx))))) begin
        found = 1'b1;
        idx   = MEM_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mbist_mem_scheduler.sv
// Walks the shared MBIST engine over the enabled memories in ascending order, collecting sticky fails.
// Optional RUN watchdog enabled by defining MBIST_SCHED_TIMEOUT_EN.
module mbist_mem_scheduler
  import mbist_mem_scheduler_pkg::*;
#(
  parameter int MEM_NUM     = 4,
  parameter int MEM_IDX_W   = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic [MEM_NUM-1:0]   i_mem_en,
  input  logic                 i_clear,
  output logic                 o_engine_start,
  input  logic                 i_engine_done,
  input  logic [MEM_NUM-1:0]   i_fail_flags,
  output logic [MEM_NUM-1:0]   o_mem_sel,
  output logic [MEM_IDX_W-1:0] o_cur_idx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [MEM_NUM-1:0]   o_fail_map,
  output logic [MEM_NUM-1:0]   o_timeout_map
);

  localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [MEM_NUM-1:0] ONE = MEM_NUM'(1);

  t_sched_state         state;
  logic [MEM_NUM-1:0]   en_q;
  logic [SET_W-1:0]     settle_cnt;
  logic [MEM_NUM-1:0]   pe_en;
  logic [MEM_IDX_W-1:0] pe_start;
  logic                 pe_incl;
  logic                 pe_found;
  logic [MEM_IDX_W-1:0] pe_idx;
  logic                 accept;
  logic                 to_hit;
  logic                 run_end;

  assign accept  = i_start && ((state == IDLE_S) || (state == DONE_S));
  assign run_end = i_engine_done || to_hit;

  // One encoder serves both the first pick (inclusive from 0) and the advance (exclusive from cur_idx).
  always_comb begin
    pe_en    = i_mem_en;
    pe_start = '0;
    pe_incl  = 1'b1;
    if (state == RUN_S) begin
      pe_en    = en_q;
      pe_start = o_cur_idx;
      pe_incl  = 1'b0;
    end
  end

  mbist_next_mem_pe #(
    .MEM_NUM   (MEM_NUM),
    .MEM_IDX_W (MEM_IDX_W)
  ) u_next_pe (
    .en        (pe_en),
    .start_idx (pe_start),
    .incl      (pe_incl),
    .found     (pe_found),
    .idx       (pe_idx)
  );

`ifdef MBIST_SCHED_TIMEOUT_EN
  localparam int RUN_CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [RUN_CNT_W-1:0] run_cnt;

  // run_cnt holds the number of RUN cycles already elapsed, so this fires on the TIMEOUT_CYC-th one.
  assign to_hit = (state == RUN_S) && !i_engine_done && (run_cnt == RUN_CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt       <= '0;
      o_timeout_map <= '0;
    end else begin
      if (state == START_S) run_cnt <= '0;
      else if (state == RUN_S) run_cnt <= run_cnt + 1'b1;
      if (accept) o_timeout_map <= '0;
      else if (to_hit) o_timeout_map[o_cur_idx] <= 1'b1;
    end
  end
`else
  assign to_hit        = 1'b0;
  assign o_timeout_map = '0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE_S;
      en_q           <= '0;
      settle_cnt     <= '0;
      o_engine_start <= 1'b0;
      o_mem_sel      <= '0;
      o_cur_idx      <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_fail_map     <= '0;
    end else begin
      o_engine_start <= 1'b0;
      case (state)
        IDLE_S, DONE_S: begin
          if (i_start) begin
            en_q       <= i_mem_en;
            o_fail_map <= '0;
            settle_cnt <= '0;
            if (pe_found) begin
              state     <= SETTLE_S;
              o_cur_idx <= pe_idx;
              o_mem_sel <= ONE << pe_idx;
              o_busy    <= 1'b1;
              o_done    <= 1'b0;
            end else begin
              state     <= DONE_S;
              o_mem_sel <= '0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
            end
          end else if ((state == DONE_S) && i_clear) begin
            state  <= IDLE_S;
            o_done <= 1'b0;
          end
        end
        SETTLE_S: begin
          if (settle_cnt == SET_W'(SETTLE_CYC)) begin
            state          <= START_S;
            settle_cnt     <= '0;
            o_engine_start <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        START_S: state <= RUN_S;
        RUN_S: begin
          o_fail_map[o_cur_idx] <= o_fail_map[o_cur_idx] | i_fail_flags[o_cur_idx] | to_hit;
          if (run_end) begin
            if (pe_found) begin
              state     <= SETTLE_S;
              o_cur_idx <= pe_idx;
              o_mem_sel <= ONE << pe_idx;
            end else begin
              state     <= DONE_S;
              o_mem_sel <= '0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
            end
          end
        end
        default: state <= IDLE_S;
      endcase
    end
  end

endmodule

// File: tb/tb_mbist_mem_scheduler.sv
// Directed bench for mbist_mem_scheduler; define MBIST_SCHED_TIMEOUT_EN to also cover the watchdog.
module tb_mbist_mem_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_start;
  logic [3:0] i_mem_en;
  logic       i_clear;
  logic       o_engine_start;
  logic       i_engine_done = 1'b0;
  logic [3:0] i_fail_flags;
  logic [3:0] o_mem_sel;
  logic [1:0] o_cur_idx;
  logic       o_busy;
  logic       o_done;
  logic [3:0] o_fail_map;
  logic [3:0] o_timeout_map;

  int cmp_cnt = 0;
  int err_cnt = 0;

  int   eng_delay = 5;
  int   eng_lat   = 0;
  int   eng_cnt   = 0;
  logic eng_armed = 1'b0;

  mbist_mem_scheduler #(
    .MEM_NUM     (4),
    .MEM_IDX_W   (2),
    .SETTLE_CYC  (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_start        (i_start),
    .i_mem_en       (i_mem_en),
    .i_clear        (i_clear),
    .o_engine_start (o_engine_start),
    .i_engine_done  (i_engine_done),
    .i_fail_flags   (i_fail_flags),
    .o_mem_sel      (o_mem_sel),
    .o_cur_idx      (o_cur_idx),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_fail_map     (o_fail_map),
    .o_timeout_map  (o_timeout_map)
  );

  always #5 clk = ~clk;

  // Engine model: one-cycle done eng_lat cycles after the start pulse; delay 0 means it never finishes.
  always @(negedge clk) begin
    i_engine_done = 1'b0;
    if (!rstn) begin
      eng_armed = 1'b0;
    end else if (o_engine_start) begin
      eng_armed = 1'b1;
      eng_cnt   = 0;
      eng_lat   = eng_delay;
    end else if (eng_armed) begin
      eng_cnt++;
      if (eng_cnt == eng_lat) begin
        i_engine_done = 1'b1;
        eng_armed     = 1'b0;
      end
    end
  end

  task automatic test_reset();
    #1;
    cmp_cnt++;
    if ({o_engine_start, o_mem_sel, o_cur_idx, o_busy, o_done, o_fail_map, o_timeout_map} !== 17'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got sel=%b idx=%0d busy=%b done=%b fail=%b to=%b start=%b want all 0",
               o_mem_sel, o_cur_idx, o_busy, o_done, o_fail_map, o_timeout_map, o_engine_start);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if ({o_busy, o_done, o_mem_sel} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_idle: got busy=%b done=%b sel=%b want 0 0 0000", o_busy, o_done, o_mem_sel);
    end
  endtask

  task automatic test_sequence();
    logic [3:0] exp_sel [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};
    int         exp_idx [3] = '{0, 1, 3};
    logic [3:0] sel_log[$];
    int         sel_c[$];
    int         st_c[$];
    int         st_idx[$];
    logic [3:0] prev = 4'b0000;
    int         done_c = 0;
    int         busy_n = 0;
    eng_delay = 5;
    @(negedge clk);
    i_mem_en = 4'b1011;
    i_start  = 1'b1;
    @(negedge clk);
    i_start  = 1'b0;
    i_mem_en = 4'b1111;
    for (int c = 1; c <= 80; c++) begin
      if (o_mem_sel !== prev) begin
        sel_log.push_back(o_mem_sel);
        sel_c.push_back(c);
        prev = o_mem_sel;
      end
      if (o_engine_start === 1'b1) begin
        st_c.push_back(c);
        st_idx.push_back(int'(o_cur_idx));
      end
      if (o_busy === 1'b1) busy_n++;
      if (o_done === 1'b1) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (done_c != 28) begin
      err_cnt++;
      $display("FAIL seq_done_cycle: got %0d want 28 (0 = never)", done_c);
    end
    cmp_cnt++;
    if (busy_n != 27) begin
      err_cnt++;
      $display("FAIL seq_busy_cycles: got %0d want 27", busy_n);
    end
    cmp_cnt++;
    if (sel_log.size() != 4 || st_c.size() != 3) begin
      err_cnt++;
      $display("FAIL seq_counts: got %0d selects %0d starts want 4 3", sel_log.size(), st_c.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        cmp_cnt++;
        if (sel_log[k] !== exp_sel[k]) begin
          err_cnt++;
          $display("FAIL seq_sel[%0d]: got %b want %b", k, sel_log[k], exp_sel[k]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        cmp_cnt++;
        if (st_c[k] - sel_c[k] != 3 || st_idx[k] != exp_idx[k]) begin
          err_cnt++;
          $display("FAIL seq_start[%0d]: got gap %0d idx %0d want gap 3 idx %0d",
                   k, st_c[k] - sel_c[k], st_idx[k], exp_idx[k]);
        end
      end
    end
    cmp_cnt++;
    if ({o_fail_map, o_timeout_map, o_busy} !== 9'b0) begin
      err_cnt++;
      $display("FAIL seq_maps: got fail=%b to=%b busy=%b want 0000 0000 0", o_fail_map, o_timeout_map, o_busy);
    end
  endtask

  task automatic test_fail_mask();
    int done_c = 0;
    @(negedge clk);
    i_mem_en     = 4'b0110;
    i_start      = 1'b1;
    i_fail_flags = 4'b0001;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 13 || c == 16) begin
        cmp_cnt++;
        if (o_fail_map !== 4'b0000) begin
          err_cnt++;
          $display("FAIL mask_pre_c%0d: got %b want 0000", c, o_fail_map);
        end
      end
      if (c == 17) begin
        cmp_cnt++;
        if (o_fail_map !== 4'b0100) begin
          err_cnt++;
          $display("FAIL mask_sticky: got %b want 0100", o_fail_map);
        end
      end
      if (o_done === 1'b1) begin
        done_c = c;
        break;
      end
      if (c == 11 || c == 16) i_fail_flags = 4'b0101;
      else i_fail_flags = 4'b0001;
      @(negedge clk);
    end
    i_fail_flags = 4'b0000;
    cmp_cnt++;
    if (done_c != 19 || o_fail_map !== 4'b0100) begin
      err_cnt++;
      $display("FAIL mask_end: got done_c=%0d fail=%b want 19 0100", done_c, o_fail_map);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    i_clear = 1'b1;
    @(negedge clk);
    i_clear = 1'b0;
    cmp_cnt++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_fail_map !== 4'b0100) begin
      err_cnt++;
      $display("FAIL clear: got done=%b busy=%b fail=%b want 0 0 0100", o_done, o_busy, o_fail_map);
    end
  endtask

  task automatic test_empty();
    int starts = 0;
    @(negedge clk);
    i_mem_en = 4'b0000;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    cmp_cnt++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_mem_sel !== 4'b0000 || o_fail_map !== 4'b0000) begin
      err_cnt++;
      $display("FAIL empty_done: got done=%b busy=%b sel=%b fail=%b want 1 0 0000 0000",
               o_done, o_busy, o_mem_sel, o_fail_map);
    end
    for (int c = 0; c < 5; c++) begin
      if (o_engine_start === 1'b1 || o_mem_sel !== 4'b0000) starts++;
      @(negedge clk);
    end
    cmp_cnt++;
    if (starts != 0) begin
      err_cnt++;
      $display("FAIL empty_quiet: got %0d active cycles want 0", starts);
    end
  endtask

  task automatic test_fail_with_done();
    eng_delay = 5;
    @(negedge clk);
    i_mem_en = 4'b1000;
    i_start  = 1'b1;
    i_clear  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_clear = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 1) begin
        cmp_cnt++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_mem_sel !== 4'b1000) begin
          err_cnt++;
          $display("FAIL start_wins: got busy=%b done=%b sel=%b want 1 0 1000", o_busy, o_done, o_mem_sel);
        end
      end
      if (c == 4) begin
        cmp_cnt++;
        if (o_engine_start !== 1'b1 || o_cur_idx !== 2'd3) begin
          err_cnt++;
          $display("FAIL fd_start: got start=%b idx=%0d want 1 3", o_engine_start, o_cur_idx);
        end
      end
      if (c == 9) begin
        cmp_cnt++;
        if (o_done !== 1'b0 || o_fail_map !== 4'b0000) begin
          err_cnt++;
          $display("FAIL fd_pre: got done=%b fail=%b want 0 0000", o_done, o_fail_map);
        end
      end
      if (c == 10) begin
        cmp_cnt++;
        if (o_done !== 1'b1 || o_fail_map !== 4'b1000 || o_mem_sel !== 4'b0000) begin
          err_cnt++;
          $display("FAIL fd_post: got done=%b fail=%b sel=%b want 1 1000 0000", o_done, o_fail_map, o_mem_sel);
        end
      end
      i_fail_flags = (c == 9) ? 4'b1000 : 4'b0000;
      if (c < 10) @(negedge clk);
    end
    i_fail_flags = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int done_c  = 0;
    int starts  = 0;
    int start_c = 0;
    eng_delay = 5;
    @(negedge clk);
    i_mem_en = 4'b0011;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) begin
        cmp_cnt++;
        if (o_fail_map !== 4'b0010 || o_mem_sel !== 4'b0010) begin
          err_cnt++;
          $display("FAIL rm_pre: got fail=%b sel=%b want 0010 0010", o_fail_map, o_mem_sel);
        end
      end else begin
        i_fail_flags = (c == 14) ? 4'b0010 : 4'b0000;
        @(negedge clk);
      end
    end
    i_fail_flags = 4'b0000;
    rstn = 1'b0;
    #1;
    cmp_cnt++;
    if ({o_engine_start, o_mem_sel, o_cur_idx, o_busy, o_done, o_fail_map, o_timeout_map} !== 17'b0) begin
      err_cnt++;
      $display("FAIL rm_reset: got sel=%b idx=%0d busy=%b done=%b fail=%b want all 0",
               o_mem_sel, o_cur_idx, o_busy, o_done, o_fail_map);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    i_mem_en = 4'b0001;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (o_engine_start === 1'b1) begin
        starts++;
        start_c = c;
      end
      if (c == 1) begin
        cmp_cnt++;
        if (o_mem_sel !== 4'b0001) begin
          err_cnt++;
          $display("FAIL rm_sel: got %b want 0001", o_mem_sel);
        end
      end
      if (o_done === 1'b1) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (done_c != 10 || starts != 1 || start_c != 4 || o_fail_map !== 4'b0000 || o_mem_sel !== 4'b0000) begin
      err_cnt++;
      $display("FAIL rm_pass: got done_c=%0d starts=%0d start_c=%0d fail=%b sel=%b want 10 1 4 0000 0000",
               done_c, starts, start_c, o_fail_map, o_mem_sel);
    end
  endtask

`ifdef MBIST_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int done_c  = 0;
    int start_c = 0;
    eng_delay = 0;
    @(negedge clk);
    i_mem_en = 4'b0011;
    i_start  = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) eng_delay = 5;
      if (o_engine_start === 1'b1) start_c = c;
      if (c == 20) begin
        cmp_cnt++;
        if (o_timeout_map !== 4'b0000 || o_fail_map !== 4'b0000 || o_mem_sel !== 4'b0001) begin
          err_cnt++;
          $display("FAIL to_pre: got to=%b fail=%b sel=%b want 0000 0000 0001", o_timeout_map, o_fail_map, o_mem_sel);
        end
      end
      if (c == 21) begin
        cmp_cnt++;
        if (o_timeout_map !== 4'b0001 || o_fail_map !== 4'b0001 || o_mem_sel !== 4'b0010) begin
          err_cnt++;
          $display("FAIL to_hit: got to=%b fail=%b sel=%b want 0001 0001 0010", o_timeout_map, o_fail_map, o_mem_sel);
        end
      end
      if (o_done === 1'b1) begin
        done_c = c;
        break;
      end
      @(negedge clk);
    end
    cmp_cnt++;
    if (done_c != 30 || start_c != 24 || o_timeout_map !== 4'b0001 || o_fail_map !== 4'b0001) begin
      err_cnt++;
      $display("FAIL to_end: got done_c=%0d start_c=%0d to=%b fail=%b want 30 24 0001 0001",
               done_c, start_c, o_timeout_map, o_fail_map);
    end
  endtask
`endif

  initial begin
    rstn         = 1'b0;
    i_start      = 1'b0;
    i_clear      = 1'b0;
    i_mem_en     = 4'b0000;
    i_fail_flags = 4'b0000;
    test_reset();
    test_sequence();
    test_fail_mask();
    test_clear();
    test_empty();
    test_fail_with_done();
    test_reset_mid();
`ifdef MBIST_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
